mips_cpu_harvard_muldiv: RTL and testbench
==========================================

Name: mips_cpu_harvard_muldiv

Overview:
- Iterative multiply/divide unit beside the main ALU in the Harvard MIPS core.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- The core's control unit starts an operation and stalls on busy while a later MFHI/MFLO/MULT/DIV is pending.

Parameters:
- ITER, 32: iterations per operation. Fixed at 32 for 32-bit operands; any other value is unsupported.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request strobe, sampled when not busy.
- op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- op_a  input  32  rs operand (multiplicand / dividend).
- op_b  input  32  rt operand (multiplier / divisor).
- mthi  input  1  write op_a to HI.
- mtlo  input  1  write op_a to LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high. On reset: state=IDLE, busy=0, done=0, hi=0, lo=0.
- Reset mid-operation aborts the operation. HI/LO are cleared and no done pulse is issued.
- States:
  - IDLE: if start=1, latch op, operand magnitudes (signed ops take the absolute value) and the result signs; clear the iteration counter; go to CALC.
  - CALC: 32 iterations, one per cycle.
  - FIX: sign correction.
  - FIX -> IDLE, writing hi/lo and pulsing done.
- busy=1 in CALC and FIX.
- Timing: start sampled at edge N. busy is high from after edge N until edge N+33. hi/lo and done take effect at edge N+33, i.e. 33 cycles after acceptance. done is high for exactly one cycle.
- Multiply:
  - Radix-2 shift-add on a 64-bit {acc, multiplier} register.
  - Signed result = negate the 64-bit product if sign(a) xor sign(b).
  - hi = product[63:32], lo = product[31:0].
- Divide:
  - Restoring division on unsigned magnitudes.
  - Quotient is negated if sign(a) xor sign(b). Remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
  - Divisor 0, all div ops, defined result: lo=0xFFFFFFFF, hi=op_a as supplied. Completes in the normal 33 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Operand magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000 with no overflow.
- start while busy is ignored: no queuing and no restart. The control unit must hold the instruction until busy=0.
- mthi/mtlo:
  - Take effect at the next edge when in IDLE with start=0.
  - If start=1 in the same IDLE cycle, the start wins and the mthi/mtlo is dropped.
  - Ignored while busy.
  - mthi and mtlo together write both HI and LO.
- hi/lo are registered and hold their value between updates. During CALC/FIX they show the previous values.
- done and start in the same cycle: a new operation can be accepted in the cycle after done (IDLE).

Test Plan:
- After reset: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy low the same cycle.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 cycles.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/7 started; at cycle 5 pulse start (MULTU 2*3) and mthi a=0x1234 -> both ignored; result lo=14, hi=2.
- In IDLE: mthi a=0xAAAA0000 then mtlo a=0x5555 -> hi=0xAAAA0000, lo=0x5555 next cycle.
- MULTU 5*5 started; reset asserted at cycle 10 -> busy=0, hi=lo=0 next cycle, no done pulse.

Source files
------------

// File: rtl/mips_cpu_harvard_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix in a final cycle.
module mips_cpu_harvard_muldiv #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mq_q, mq_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_p_q, neg_p_d;
  logic        neg_r_q, neg_r_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted;
  logic [32:0] sum;
  logic [63:0] prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    signed_op = ~op[0];
    abs_a     = (signed_op && op_a[31]) ? -op_a : op_a;
    abs_b     = (signed_op && op_b[31]) ? -op_b : op_b;
    shifted   = {acc_q, mq_q[31]};
    sum       = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : 33'd0);
    prod      = {acc_q, mq_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_p_d  = signed_op & (op_a[31] ^ op_b[31]);
          neg_r_d  = signed_op & op_a[31];
          div0_d   = op[1] & (op_b == '0);
          acc_d    = '0;
          cnt_d    = '0;
          // Divide shifts the dividend out of mq; multiply shifts the multiplier out.
          if (op[1]) begin
            mq_d   = abs_a;
            opnd_d = abs_b;
          end else begin
            mq_d   = abs_b;
            opnd_d = abs_a;
          end
          state_d = S_CALC;
        end else begin
          if (mthi) hi_d = op_a;
          if (mtlo) lo_d = op_a;
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          // A zero divisor always "fits", giving all-ones quotient and |a| remainder.
          if (shifted >= {1'b0, opnd_q}) begin
            acc_d = shifted[31:0] - opnd_q;
            mq_d  = {mq_q[30:0], 1'b1};
          end else begin
            acc_d = shifted[31:0];
            mq_d  = {mq_q[30:0], 1'b0};
          end
        end else begin
          acc_d = sum[32:1];
          mq_d  = {sum[0], mq_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          lo_d = div0_q ? '1 : (neg_p_q ? -mq_q : mq_q);
          hi_d = neg_r_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_p_q ? -prod : prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_harvard_muldiv.sv
// Scoreboard bench for the multiply/divide unit: expected {hi,lo} queued at issue, compared on done.
module tb_mips_cpu_harvard_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  mips_cpu_harvard_muldiv #(.ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint q, r;
    if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return 64'(ua * ub);
      2'd2: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
      default: begin q = ua / ub; r = ua % ub; return {r[31:0], q[31:0]}; end
    endcase
  endfunction

  // Issue one operation; optionally inject a start+mthi while busy at cycle inject_at.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int inject_at);
    int k;
    bit seen;
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0; op_a = '0; op_b = '0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      if (k == inject_at) begin
        start = 1'b1; op = 2'd1; op_a = 32'h1234; op_b = 32'd3; mthi = 1'b1;
      end
      @(posedge clk); #1;
      if (k == inject_at) begin
        start = 1'b0; mthi = 1'b0; op_a = '0; op_b = '0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_latency"}, seen ? 64'(k) : 64'd0, 64'd33);
    e = sb_q.pop_front();
    if (seen) begin
      check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      check({tag, "_idle"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic move_to(input string tag, input logic w_hi, input logic w_lo,
                         input logic [31:0] a, input logic [63:0] exp);
    logic [63:0] e;
    @(negedge clk);
    mthi = w_hi; mtlo = w_lo; op_a = a;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0; op_a = '0;
    e = sb_q.pop_front();
    check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
  endtask

  initial begin
    int pulses;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 0);
    run_op("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF, 0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
    run_op("divu_ignore", 2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 5);

    move_to("mthi", 1'b1, 1'b0, 32'hAAAA_0000, {32'hAAAA_0000, 32'h0000_000E});
    move_to("mtlo", 1'b0, 1'b1, 32'h0000_5555, {32'hAAAA_0000, 32'h0000_5555});
    move_to("mtboth", 1'b1, 1'b1, 32'h0BAD_F00D, {32'h0BAD_F00D, 32'h0BAD_F00D});

    // start and mthi in the same idle cycle: the operation wins
    @(negedge clk);
    mthi = 1'b1;
    run_op("start_wins", 2'd1, 32'd6, 32'd7, 64'd42, 0);
    mthi = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = (i == 9) ? 32'h8000_0000 : $urandom();
      if (i == 4) rb = 32'd1;
      run_op("rand", ro, ra, rb, model(ro, ra, rb), 0);
    end

    run_op("multu_pre", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    @(negedge clk);
    start = 1'b1; op = 2'd1; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
